// File: rtl/usb_desc_reader.sv
// rtl/usb_desc_reader.sv - EP0 GET_DESCRIPTOR reader streaming descriptor ROM bytes in packets
// romAddr is the ROM's address register: romData reflects it during the following cycle.
module usb_desc_reader #(
  parameter int ROM_ADDR_WID = 9,
  parameter int NUM_CONFIGS  = 1,
  parameter int NUM_STRINGS  = 0,
  localparam int LUT_ENTRIES = NUM_CONFIGS + NUM_STRINGS + ((NUM_STRINGS > 0) ? 1 : 0)
) (
  input  logic                              clk48,
  input  logic                              rst,
  input  logic [LUT_ENTRIES*ROM_ADDR_WID-1:0] descStartLut,
  input  logic [6:0]                        maxPacketSize,
  input  logic                              reqValid,
  output logic                              reqReady,
  input  logic [7:0]                        reqDescType,
  input  logic [7:0]                        reqDescIdx,
  input  logic [15:0]                       reqLength,
  output logic                              reqError,
  output logic [ROM_ADDR_WID-1:0]           romAddr,
  input  logic [7:0]                        romData,
  output logic                              dataValid,
  input  logic                              dataReady,
  output logic [7:0]                        data,
  output logic                              dataLastOfPacket,
  output logic                              zlpValid,
  input  logic                              packetAck,
  input  logic                              packetRetry,
  output logic                              xferDone
);

  typedef enum logic [2:0] {IDLE, CHECK, LEN_LO, LEN_HI, FETCH, PRESENT, WAIT_ACK, ZLP} state_t;

  state_t                  state;
  logic [7:0]              desc_type, desc_idx, len_lo;
  logic [15:0]             req_len, xfer_len, byte_idx, pkt_start;
  logic [ROM_ADDR_WID-1:0] start, lut_start, start_sel;
  int                      lut_sel;
  logic                    idx_ok;
  logic [15:0]             desc_len, clamp_len, next_idx, pkt_bytes, mps, mps_mask;

  always_comb begin
    lut_sel = (desc_type == 8'd3) ? NUM_CONFIGS + int'(desc_idx) : int'(desc_idx);
    lut_start = '0;
    for (int i = 0; i < LUT_ENTRIES; i++)
      if (i == lut_sel) lut_start = descStartLut[i*ROM_ADDR_WID +: ROM_ADDR_WID];
    case (desc_type)
      8'd1:    idx_ok = (desc_idx == 8'd0);
      8'd2:    idx_ok = int'(desc_idx) < NUM_CONFIGS;
      8'd3:    idx_ok = (NUM_STRINGS > 0) && (int'(desc_idx) <= NUM_STRINGS);
      default: idx_ok = 1'b0;
    endcase
    start_sel = (desc_type == 8'd1) ? '0 : lut_start;
    // Config length is wTotalLength; device/string length is bLength.
    desc_len  = (state == LEN_HI) ? {romData, len_lo} : {8'd0, romData};
    clamp_len = (desc_len < req_len) ? desc_len : req_len;
    next_idx  = byte_idx + 16'd1;
    pkt_bytes = next_idx - pkt_start;
    mps       = {9'd0, maxPacketSize};
    mps_mask  = mps - 16'd1;
  end

  always_ff @(posedge clk48 or posedge rst) begin
    if (rst) begin
      state            <= IDLE;
      reqReady         <= 1'b1;
      reqError         <= 1'b0;
      romAddr          <= '0;
      dataValid        <= 1'b0;
      data             <= 8'd0;
      dataLastOfPacket <= 1'b0;
      zlpValid         <= 1'b0;
      xferDone         <= 1'b0;
      desc_type        <= 8'd0;
      desc_idx         <= 8'd0;
      len_lo           <= 8'd0;
      req_len          <= 16'd0;
      xfer_len         <= 16'd0;
      byte_idx         <= 16'd0;
      pkt_start        <= 16'd0;
      start            <= '0;
    end else begin
      reqError <= 1'b0;
      xferDone <= 1'b0;
      case (state)
        IDLE: if (reqValid) begin
          desc_type <= reqDescType;
          desc_idx  <= reqDescIdx;
          req_len   <= reqLength;
          reqReady  <= 1'b0;
          state     <= CHECK;
        end
        CHECK: if (!idx_ok) begin
          reqError <= 1'b1;
          reqReady <= 1'b1;
          state    <= IDLE;
        end else begin
          start   <= start_sel;
          romAddr <= (desc_type == 8'd2) ? start_sel + ROM_ADDR_WID'(2) : start_sel;
          state   <= LEN_LO;
        end
        LEN_LO, LEN_HI: if (state == LEN_LO && desc_type == 8'd2) begin
          len_lo  <= romData;
          romAddr <= start + ROM_ADDR_WID'(3);
          state   <= LEN_HI;
        end else begin
          xfer_len  <= clamp_len;
          byte_idx  <= 16'd0;
          pkt_start <= 16'd0;
          romAddr   <= start;
          if (clamp_len == 16'd0) begin
            zlpValid <= 1'b1;
            state    <= ZLP;
          end else begin
            state <= FETCH;
          end
        end
        FETCH: begin
          data             <= romData;
          dataValid        <= 1'b1;
          dataLastOfPacket <= (next_idx == xfer_len) || (pkt_bytes == mps);
          state            <= PRESENT;
        end
        PRESENT: if (dataReady) begin
          dataValid        <= 1'b0;
          dataLastOfPacket <= 1'b0;
          if (dataLastOfPacket) begin
            state <= WAIT_ACK;
          end else begin
            byte_idx <= next_idx;
            romAddr  <= start + next_idx[ROM_ADDR_WID-1:0];
            state    <= FETCH;
          end
        end
        WAIT_ACK: if (packetRetry) begin
          byte_idx <= pkt_start;
          romAddr  <= start + pkt_start[ROM_ADDR_WID-1:0];
          state    <= FETCH;
        end else if (packetAck) begin
          if (next_idx < xfer_len) begin
            pkt_start <= next_idx;
            byte_idx  <= next_idx;
            romAddr   <= start + next_idx[ROM_ADDR_WID-1:0];
            state     <= FETCH;
          end else if (xfer_len < req_len && (xfer_len & mps_mask) == 16'd0) begin
            zlpValid <= 1'b1;
            state    <= ZLP;
          end else begin
            xferDone <= 1'b1;
            reqReady <= 1'b1;
            state    <= IDLE;
          end
        end
        ZLP: if (packetAck && !packetRetry) begin
          zlpValid <= 1'b0;
          xferDone <= 1'b1;
          reqReady <= 1'b1;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_usb_desc_reader.sv
// tb/tb_usb_desc_reader.sv - directed self-checking bench for usb_desc_reader
module tb_usb_desc_reader;

  logic        clk48 = 1'b0;
  logic        rst = 1'b1;
  logic [8:0]  descStartLut = 9'd18;
  logic [6:0]  maxPacketSize = 7'd64;
  logic        reqValid = 1'b0;
  logic        reqReady;
  logic [7:0]  reqDescType = 8'd0;
  logic [7:0]  reqDescIdx = 8'd0;
  logic [15:0] reqLength = 16'd0;
  logic        reqError;
  logic [8:0]  romAddr;
  logic [7:0]  romData;
  logic        dataValid;
  logic        dataReady = 1'b1;
  logic [7:0]  data;
  logic        dataLastOfPacket;
  logic        zlpValid;
  logic        packetAck = 1'b0;
  logic        packetRetry = 1'b0;
  logic        xferDone;

  logic [7:0]  rom [0:511];
  logic [7:0]  got[$];
  logic        got_last[$];
  int          zlp_cnt, done_cnt;
  int          checks = 0, errors = 0;

  assign romData = rom[romAddr];
  always #5 clk48 = ~clk48;

  usb_desc_reader dut (
    .clk48(clk48), .rst(rst), .descStartLut(descStartLut), .maxPacketSize(maxPacketSize),
    .reqValid(reqValid), .reqReady(reqReady), .reqDescType(reqDescType), .reqDescIdx(reqDescIdx),
    .reqLength(reqLength), .reqError(reqError), .romAddr(romAddr), .romData(romData),
    .dataValid(dataValid), .dataReady(dataReady), .data(data), .dataLastOfPacket(dataLastOfPacket),
    .zlpValid(zlpValid), .packetAck(packetAck), .packetRetry(packetRetry), .xferDone(xferDone)
  );

  task automatic tick();
    @(posedge clk48);
    #1;
  endtask

  task automatic check_idle_outputs(input string name);
    checks++;
    if (reqReady !== 1'b1 || dataValid !== 1'b0 || zlpValid !== 1'b0 || xferDone !== 1'b0 ||
        reqError !== 1'b0 || dataLastOfPacket !== 1'b0 || romAddr !== 9'd0) begin
      errors++;
      $display("FAIL %s: rdy=%b dv=%b zlp=%b done=%b err=%b last=%b addr=%0d, required 1 0 0 0 0 0 0",
               name, reqReady, dataValid, zlpValid, xferDone, reqError, dataLastOfPacket, romAddr);
    end
  endtask

  task automatic send_req(input logic [7:0] t, input logic [7:0] idx, input logic [15:0] len,
                          input logic [6:0] mps);
    checks++;
    if (reqReady !== 1'b1) begin
      errors++;
      $display("FAIL req_ready: got %b, required 1", reqReady);
    end
    maxPacketSize = mps;
    reqDescType = t;
    reqDescIdx = idx;
    reqLength = len;
    reqValid = 1'b1;
    tick();
    reqValid = 1'b0;
  endtask

  task automatic run_xfer(input logic [7:0] t, input logic [7:0] idx, input logic [15:0] len,
                          input logic [6:0] mps, input int retry_pkt);
    int pkts = 0;
    bit retried = 0, ack_pending = 0, done = 0;
    got.delete();
    got_last.delete();
    zlp_cnt = 0;
    done_cnt = 0;
    dataReady = 1'b1;
    send_req(t, idx, len, mps);
    for (int cyc = 0; cyc < 3000 && !done; cyc++) begin
      if (xferDone) begin
        done_cnt++;
        done = 1;
      end
      if (packetAck || packetRetry) begin
        packetAck = 1'b0;
        packetRetry = 1'b0;
      end else if (ack_pending) begin
        ack_pending = 0;
        if (pkts == retry_pkt && !retried) begin
          packetRetry = 1'b1;
          retried = 1;
        end else begin
          packetAck = 1'b1;
        end
      end else if (zlpValid) begin
        zlp_cnt++;
        packetAck = 1'b1;
      end
      if (dataValid) begin
        got.push_back(data);
        got_last.push_back(dataLastOfPacket);
        if (dataLastOfPacket) begin
          pkts++;
          ack_pending = 1;
        end
      end
      if (!done) tick();
    end
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL xfer_timeout: xferDone not seen, required within 3000 cycles");
    end
  endtask

  task automatic check_xfer(input string name, input int start, input int xfer, input int mps,
                            input int retry_pkt, input int exp_zlp);
    logic [7:0] eb[$];
    logic       el[$];
    int off = 0, p = 0, plen, n;
    while (off < xfer) begin
      plen = (xfer - off < mps) ? xfer - off : mps;
      p++;
      for (int r = 0; r < ((p == retry_pkt) ? 2 : 1); r++)
        for (int j = 0; j < plen; j++) begin
          eb.push_back(rom[start + off + j]);
          el.push_back(j == plen - 1);
        end
      off += plen;
    end
    checks++;
    if (got.size() != eb.size()) begin
      errors++;
      $display("FAIL %s_count: got %0d bytes, required %0d", name, got.size(), eb.size());
    end
    n = (got.size() < eb.size()) ? got.size() : eb.size();
    for (int k = 0; k < n; k++) begin
      checks++;
      if (got[k] !== eb[k] || got_last[k] !== el[k]) begin
        errors++;
        $display("FAIL %s_byte%0d: got %02h last=%b, required %02h last=%b",
                 name, k, got[k], got_last[k], eb[k], el[k]);
      end
    end
    checks++;
    if (zlp_cnt != exp_zlp) begin
      errors++;
      $display("FAIL %s_zlp: got %0d, required %0d", name, zlp_cnt, exp_zlp);
    end
    checks++;
    if (done_cnt != 1) begin
      errors++;
      $display("FAIL %s_done: got %0d, required 1", name, done_cnt);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    tick();
    check_idle_outputs("reset");
  endtask

  task automatic test_device();
    run_xfer(8'd1, 8'd0, 16'd64, 7'd64, 0);
    check_xfer("device", 0, 18, 64, 0, 0);
  endtask

  task automatic test_truncate();
    run_xfer(8'd1, 8'd0, 16'd8, 7'd64, 0);
    check_xfer("truncate", 0, 8, 64, 0, 0);
  endtask

  task automatic test_zero_length();
    run_xfer(8'd1, 8'd0, 16'd0, 7'd64, 0);
    check_xfer("zero_len", 0, 0, 64, 0, 1);
  endtask

  task automatic test_config();
    run_xfer(8'd2, 8'd0, 16'd255, 7'd8, 0);
    check_xfer("config", 18, 32, 8, 0, 1);
  endtask

  task automatic test_retry();
    run_xfer(8'd2, 8'd0, 16'd255, 7'd8, 2);
    check_xfer("retry", 18, 32, 8, 2, 1);
  endtask

  task automatic test_errors();
    logic [7:0] types [4] = '{8'd3, 8'd1, 8'd6, 8'd2};
    logic [7:0] idxs  [4] = '{8'd0, 8'd1, 8'd0, 8'd1};
    for (int v = 0; v < 4; v++) begin
      int err_cnt = 0, dv_cnt = 0;
      send_req(types[v], idxs[v], 16'd64, 7'd64);
      for (int c = 0; c < 8; c++) begin
        if (reqError) err_cnt++;
        if (dataValid) dv_cnt++;
        tick();
      end
      checks++;
      if (err_cnt != 1 || dv_cnt != 0 || reqReady !== 1'b1) begin
        errors++;
        $display("FAIL error_t%0d_i%0d: err=%0d dv=%0d rdy=%b, required 1 0 1",
                 types[v], idxs[v], err_cnt, dv_cnt, reqReady);
      end
    end
  endtask

  task automatic test_backpressure_reset();
    int waited = 0, unstable = 0;
    dataReady = 1'b0;
    send_req(8'd1, 8'd0, 16'd64, 7'd64);
    while (!dataValid && waited < 20) begin
      tick();
      waited++;
    end
    checks++;
    if (!dataValid || data !== 8'd18 || dataLastOfPacket !== 1'b0) begin
      errors++;
      $display("FAIL bp_first: dv=%b data=%0d last=%b, required 1 18 0", dataValid, data, dataLastOfPacket);
    end
    for (int c = 0; c < 10; c++) begin
      tick();
      if (dataValid !== 1'b1 || data !== 8'd18) unstable++;
    end
    checks++;
    if (unstable != 0) begin
      errors++;
      $display("FAIL bp_stable: %0d unstable cycles, required 0", unstable);
    end
    dataReady = 1'b1;
    tick();
    dataReady = 1'b0;
    waited = 0;
    while (!dataValid && waited < 20) begin
      tick();
      waited++;
    end
    checks++;
    if (!dataValid || data !== rom[1]) begin
      errors++;
      $display("FAIL bp_second: dv=%b data=%02h, required 1 %02h", dataValid, data, rom[1]);
    end
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    tick();
    check_idle_outputs("reset_mid_packet");
    dataReady = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < 512; i++) rom[i] = 8'((i * 7 + 3) & 255);
    rom[0] = 8'd18;
    rom[20] = 8'd32;
    rom[21] = 8'd0;
    test_reset();
    test_device();
    test_truncate();
    test_zero_length();
    test_config();
    test_retry();
    test_errors();
    test_backpressure_reset();
    test_truncate();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/usb_desc_reader.md
Name: usb_desc_reader

Overview:
- Serves GET_DESCRIPTOR requests on EP0 by reading the packed descriptor ROM generated from the device EP configuration.
- Resolves each descriptor's start address through the descriptor start LUT, determines its length from the ROM, and clamps that length to wLength.
- Streams the bytes to the EP0 IN path in packets of at most maxPacketSize. Supports packet retry (NAK/timeout) and zero-length-packet termination.

Parameters:
- ROM_ADDR_WID, 9: byte address width of the descriptor ROM.
- NUM_CONFIGS, 1: configuration descriptors; LUT entries 0..NUM_CONFIGS-1.
- NUM_STRINGS, 0: string descriptors excluding string zero. If >0, LUT entry NUM_CONFIGS is string zero and NUM_CONFIGS+k is string k (k = 1..NUM_STRINGS).

Ports:
- clk48 in 1: clock.
- rst in 1: asynchronous, active-high reset.
- descStartLut in (NUM_CONFIGS+NUM_STRINGS+(NUM_STRINGS>0))*ROM_ADDR_WID: flat LUT of start addresses; entry i occupies bits [i*W +: W]. The device descriptor is always at address 0.
- maxPacketSize in 7: EP0 max packet size, one of 8/16/32/64.
- reqValid in 1: request strobe.
- reqReady out 1: high only in IDLE.
- reqDescType in 8: 1 = DEVICE, 2 = CONFIGURATION, 3 = STRING.
- reqDescIdx in 8: descriptor index.
- reqLength in 16: wLength.
- reqError out 1: one-cycle pulse for an unsupported request; EP0 stalls.
- romAddr out ROM_ADDR_WID: synchronous ROM address.
- romData in 8: ROM byte, valid one cycle after romAddr.
- dataValid out 1, dataReady in 1, data out 8: byte stream, valid/ready handshake.
- dataLastOfPacket out 1: qualifies the final byte of the current packet.
- zlpValid out 1: request for a zero-length packet; held until packetAck.
- packetAck in 1: host ACKed the current packet; advance.
- packetRetry in 1: resend the current packet from its first byte.
- xferDone out 1: one-cycle pulse after the final packet is ACKed.

Behaviour:
- Reset values: reqReady=1 once in IDLE; dataValid, zlpValid, reqError, xferDone, dataLastOfPacket = 0; romAddr = 0; all counters = 0.
- Reset mid-transfer aborts immediately to IDLE with no xferDone.
- FSM states: IDLE, CHECK, LEN_LO, LEN_HI, FETCH, PRESENT, WAIT_ACK, ZLP.
- IDLE: on reqValid, latch type, idx and reqLength → CHECK.
- CHECK: evaluates validity and sets the start address.
  - Invalid when: type ∉ {1,2,3}; DEVICE with idx≠0; CONFIGURATION with idx ≥ NUM_CONFIGS; STRING with NUM_STRINGS=0 or idx > NUM_STRINGS.
  - Invalid → reqError pulse, → IDLE.
  - Valid → set start = 0 (DEVICE) or the LUT entry.
  - romAddr = start for DEVICE/STRING (length = bLength at byte 0); romAddr = start+2 for CONFIGURATION (wTotalLength, little endian).
- LEN_LO: sample the low length byte.
  - DEVICE/STRING: descLen = {8'b0, romData}.
  - CONFIGURATION: set romAddr = start+3 → LEN_HI.
- LEN_HI: descLen[15:8] = romData.
- Transfer length: xferLen = min(descLen, reqLength), unsigned 16-bit.
  - xferLen == 0 → ZLP.
  - Otherwise byteIdx = 0, pktStart = 0 → FETCH.
- FETCH: romAddr = start + byteIdx (truncated to ROM_ADDR_WID, wraps modulo ROM size) → PRESENT.
- PRESENT:
  - data is registered from romData; dataValid=1 and held stable until dataReady.
  - dataLastOfPacket=1 when byteIdx+1 == xferLen or (byteIdx - pktStart + 1) == maxPacketSize.
  - Throughput is at most one byte per 2 cycles.
- On handshake:
  - If last of packet → WAIT_ACK.
  - Else byteIdx++ → FETCH.
- WAIT_ACK:
  - packetRetry → byteIdx = pktStart → FETCH.
  - packetAck, bytes remain → pktStart = byteIdx+1, byteIdx++ → FETCH.
  - packetAck, all bytes sent, and xferLen < reqLength and xferLen % maxPacketSize == 0 → ZLP.
  - packetAck, otherwise → xferDone pulse, → IDLE.
  - packetAck and packetRetry asserted together: retry wins.
- ZLP: zlpValid=1.
  - packetAck → xferDone pulse, → IDLE.
  - packetRetry keeps zlpValid asserted.
- Requests arriving outside IDLE are ignored, since reqReady=0.

Test Plan:
- Device descriptor: ROM[0]=18, maxPacketSize=64, reqLength=64 → 18 bytes equal to ROM[0..17] in one packet; dataLastOfPacket on byte 18; no ZLP; xferDone after packetAck.
- Truncation: same descriptor, reqLength=8 → exactly 8 bytes, last flag on byte 8, xferDone, no ZLP.
- Configuration 0: LUT[0]=18, ROM[20]=32, ROM[21]=0, maxPacketSize=8, reqLength=255 → packets of 8/8/8/8 bytes from ROM[18..49], then zlpValid, then xferDone after the 5th ack.
- Retry: during the config transfer, assert packetRetry after packet 2 → packet 2 resent with bytes ROM[26..33] identical; transfer then completes normally.
- Errors: NUM_STRINGS=0 with type=3 idx=0 → reqError pulse, no dataValid. Also type=1 idx=1 → reqError; type=6 → reqError.
- Backpressure/reset: hold dataReady=0 for 10 cycles → data stable, dataValid held. Assert rst mid-packet → all outputs 0 and reqReady=1 on the first cycle after release.
